// File: rtl/imem_pkg.sv
// Shared constants and state type for the instruction-memory loader.
package imem_pkg;

    localparam int unsigned IMEM_ADDR_W = 6;
    localparam int unsigned IMEM_DEPTH  = 64;
    localparam logic [31:0] HALT_WORD   = 32'h0000_007F;

    typedef enum logic [1:0] {
        COLLECT,
        WRITE,
        DONE
    } loader_state_e;

endpackage : imem_pkg

// File: rtl/byte_packer.sv
// Packs a stream of accepted bytes little-endian into 32-bit words.
// The top byte is never stored; word/word_valid present it directly so the
// completed word is usable on the same edge that accepts byte 3.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_cnt_q;
    logic [23:0] low_q;

    // Byte counter and storage for the three low bytes of the word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= '0;
            low_q      <= '0;
        end else if (clear) begin
            byte_cnt_q <= '0;
            low_q      <= '0;
        end else if (accept) begin
            case (byte_cnt_q)
                2'd0:    low_q[7:0]   <= in_data;
                2'd1:    low_q[15:8]  <= in_data;
                2'd2:    low_q[23:16] <= in_data;
                default: ;
            endcase
            byte_cnt_q <= byte_cnt_q + 2'd1;
        end
    end

    // Completed word is the stored low bytes plus the byte arriving now
    always_comb begin
        word       = {in_data, low_q};
        word_valid = accept && (byte_cnt_q == 2'd3);
    end

endmodule : byte_packer

// File: rtl/imem_loader.sv
// Instruction-memory loader: writes a byte-streamed program to consecutive
// word addresses and holds the CPU until HALT_WORD or the memory is full.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W    = imem_pkg::IMEM_ADDR_W,
    parameter int unsigned DEPTH     = imem_pkg::IMEM_DEPTH,
    parameter logic [31:0] HALT_WORD = imem_pkg::HALT_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

    loader_state_e     state_q;
    logic [ADDR_W-1:0] word_addr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_data_q;
    logic              mem_wren_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              overflow_q;
    logic              in_ready_q;
    logic [ADDR_W:0]   word_count_q;

    logic              accept;
    logic              clear;
    logic [31:0]       word;
    logic              word_valid;

    // Handshake and packer control
    always_comb begin
        accept = in_valid && in_ready_q;
        clear  = (state_q == DONE) && reload;
    end

    byte_packer u_packer (
        .clk        (clk),
        .rst        (reset),
        .clear      (clear),
        .accept     (accept),
        .in_data    (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // Loader FSM with all outputs registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= COLLECT;
            word_addr_q  <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_wren_q   <= 1'b0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            word_count_q <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (word_valid) begin
                        state_q    <= WRITE;
                        mem_wren_q <= 1'b1;
                        mem_addr_q <= word_addr_q;
                        mem_data_q <= word;
                        in_ready_q <= 1'b0;
                    end
                end
                WRITE: begin
                    mem_wren_q   <= 1'b0;
                    word_count_q <= word_count_q + 1'b1;
                    if (mem_data_q == HALT_WORD) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                        overflow_q <= 1'b0;
                    end else if (word_addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                        overflow_q <= 1'b1;
                    end else begin
                        state_q     <= COLLECT;
                        word_addr_q <= word_addr_q + 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (reload) begin
                        state_q      <= COLLECT;
                        word_addr_q  <= '0;
                        word_count_q <= '0;
                        cpu_hold_q   <= 1'b1;
                        done_q       <= 1'b0;
                        overflow_q   <= 1'b0;
                        in_ready_q   <= 1'b1;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    // Drive ports from their registers
    always_comb begin
        in_ready   = in_ready_q;
        mem_addr   = mem_addr_q;
        mem_data   = mem_data_q;
        mem_wren   = mem_wren_q;
        cpu_hold   = cpu_hold_q;
        done       = done_q;
        overflow   = overflow_q;
        word_count = word_count_q;
    end

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        reload;
    logic [5:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic        cpu_hold;
    logic        done;
    logic        overflow;
    logic [6:0]  word_count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [5:0]  log_addr [0:511];
    logic [31:0] log_data [0:511];
    int unsigned log_n = 0;

    imem_loader #(
        .ADDR_W    (6),
        .DEPTH     (64),
        .HALT_WORD (32'h0000_007F)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .reload     (reload),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write recorder: one entry per cycle with mem_wren high
    always @(negedge clk) begin
        if (mem_wren === 1'b1) begin
            if (log_n < 512) begin
                log_addr[log_n] = mem_addr;
                log_data[log_n] = mem_data;
            end
            log_n++;
            check("hold_during_write", {31'b0, cpu_hold}, 32'd1);
        end
    end

    // Inputs change on the falling edge; the rising edge accepts
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_err++;
            $error("FAIL send_timeout: observed in_ready %b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int unsigned base;
    logic [31:0] w;

    initial begin
        reset    = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        reload   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_in_ready",   {31'b0, in_ready}, 32'd1);
        check("rst_cpu_hold",   {31'b0, cpu_hold}, 32'd1);
        check("rst_done",       {31'b0, done}, 32'd0);
        check("rst_overflow",   {31'b0, overflow}, 32'd0);
        check("rst_word_count", {25'b0, word_count}, 32'd0);
        check("rst_wren",       {31'b0, mem_wren}, 32'd0);
        check("rst_addr",       {26'b0, mem_addr}, 32'd0);
        check("rst_data",       mem_data, 32'd0);

        // 1: single word, back-to-back bytes
        base = log_n;
        send_word(32'h0080_0293, 0);
        check("t1_wren",     {31'b0, mem_wren}, 32'd1);
        check("t1_addr",     {26'b0, mem_addr}, 32'd0);
        check("t1_data",     mem_data, 32'h0080_0293);
        check("t1_ready_lo", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        check("t1_wren_off", {31'b0, mem_wren}, 32'd0);
        check("t1_count",    {25'b0, word_count}, 32'd1);
        check("t1_hold",     {31'b0, cpu_hold}, 32'd1);
        check("t1_ready_hi", {31'b0, in_ready}, 32'd1);
        check("t1_nwrites",  log_n - base, 32'd1);

        // 2: three words then the halt word
        do_reset();
        base = log_n;
        send_word(32'h0080_0293, 0);
        send_word(32'h0010_0313, 0);
        send_word(32'h0062_83B3, 0);
        send_word(32'h0000_007F, 0);
        @(negedge clk);
        check("t2_done",     {31'b0, done}, 32'd1);
        check("t2_hold",     {31'b0, cpu_hold}, 32'd0);
        check("t2_overflow", {31'b0, overflow}, 32'd0);
        check("t2_count",    {25'b0, word_count}, 32'd4);
        check("t2_nwrites",  log_n - base, 32'd4);
        for (int i = 0; i < 4; i++) check("t2_addr", {26'b0, log_addr[base + i]}, i);
        check("t2_data1", log_data[base + 1], 32'h0010_0313);
        check("t2_data3", log_data[base + 3], 32'h0000_007F);

        // 3: fill all 64 words without a halt
        do_reset();
        base = log_n;
        for (int i = 0; i < 64; i++) begin
            w = 32'hC0DE_0000 | i;
            send_word(w, 0);
        end
        @(negedge clk);
        check("t3_done",     {31'b0, done}, 32'd1);
        check("t3_overflow", {31'b0, overflow}, 32'd1);
        check("t3_hold",     {31'b0, cpu_hold}, 32'd0);
        check("t3_count",    {25'b0, word_count}, 32'd64);
        check("t3_nwrites",  log_n - base, 32'd64);
        check("t3_addr0",    {26'b0, log_addr[base]}, 32'd0);
        check("t3_addr63",   {26'b0, log_addr[base + 63]}, 32'd63);
        check("t3_data63",   log_data[base + 63], 32'hC0DE_003F);
        in_data  = 8'hEE;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("t3_no_ready",   {31'b0, in_ready}, 32'd0);
        check("t3_no_extra",   log_n - base, 32'd64);
        check("t3_still_done", {31'b0, done}, 32'd1);
        in_valid = 1'b0;

        // 5: reload from DONE, then load only the halt word
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("t5_hold",     {31'b0, cpu_hold}, 32'd1);
        check("t5_done_lo",  {31'b0, done}, 32'd0);
        check("t5_ovf_lo",   {31'b0, overflow}, 32'd0);
        check("t5_count0",   {25'b0, word_count}, 32'd0);
        check("t5_ready",    {31'b0, in_ready}, 32'd1);
        base = log_n;
        send_word(32'h0000_007F, 0);
        @(negedge clk);
        check("t5_addr",     {26'b0, log_addr[base]}, 32'd0);
        check("t5_nwrites",  log_n - base, 32'd1);
        check("t5_done",     {31'b0, done}, 32'd1);
        check("t5_count",    {25'b0, word_count}, 32'd1);

        // 4: asynchronous reset while writing, then mid-word
        do_reset();
        send_word(32'h1122_3344, 0);
        check("t4_wren_pre", {31'b0, mem_wren}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("t4_async_wren", {31'b0, mem_wren}, 32'd0);
        check("t4_async_hold", {31'b0, cpu_hold}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        send_word(32'h1122_3344, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #1 reset = 1'b1;
        #1;
        check("t4_mid_hold", {31'b0, cpu_hold}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        base = log_n;
        send_word(32'h5566_7788, 0);
        @(negedge clk);
        check("t4_nwrites", log_n - base, 32'd1);
        check("t4_addr",    {26'b0, log_addr[base]}, 32'd0);
        check("t4_data",    log_data[base], 32'h5566_7788);

        // 6: valid one cycle in three
        do_reset();
        base = log_n;
        send_word(32'h0080_0293, 2);
        @(negedge clk);
        check("t6_nwrites", log_n - base, 32'd1);
        check("t6_data",    log_data[base], 32'h0080_0293);
        check("t6_addr",    {26'b0, log_addr[base]}, 32'd0);
        check("t6_count",   {25'b0, word_count}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_imem_loader
